piano_key_ctrl: RTL



---
 rtl/piano_key_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/piano_key_ctrl.sv
// Piano key front end: sync, debounce, last-pressed-wins arbitration
// and a minimum note length for the note-frequency divider.
`timescale 1ns/1ps
module piano_key_ctrl #(
    parameter int unsigned DEB_CYCLES  = 500000,
    parameter int unsigned HOLD_CYCLES = 2500000
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [7:0] keys,
    output logic [2:0] scaler,
    output logic       note_on,
    output logic [7:0] active_key
);

    typedef enum logic [1:0] {IDLE, PLAY, TAIL} state_t;

    localparam logic [19:0] TICK_LAST = 20'(DEB_CYCLES - 1);
    localparam logic [21:0] HOLD_LOAD = 22'(HOLD_CYCLES - 1);

    state_t      state, state_n;
    logic [7:0]  sync1, sync2, samp, deb, deb_q;
    logic [19:0] tick_cnt;
    logic        tick;
    logic [21:0] hold_cnt, hold_n;
    logic [2:0]  cur_n;
    logic [7:0]  press;
    logic        rel;
    logic        note_on_n;
    logic [7:0]  active_n;

    function automatic logic [2:0] top_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) idx = i[2:0];
        return idx;
    endfunction

    assign tick  = (tick_cnt == TICK_LAST);
    assign press = deb & ~deb_q;
    assign rel   = deb_q[scaler] & ~deb[scaler];

    // Two-flop synchroniser on the raw key levels
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
        end
    end

    // Free-running debounce sample timer
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) tick_cnt <= '0;
        else        tick_cnt <= tick ? '0 : tick_cnt + 20'd1;
    end

    // Accept a level only when it matches the previous tick's sample
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            samp <= '0;
            deb  <= '0;
        end else if (tick) begin
            samp <= sync2;
            deb  <= (~(samp ^ sync2) & sync2) | ((samp ^ sync2) & deb);
        end
    end

    // Previous debounced vector for edge detection
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) deb_q <= '0;
        else        deb_q <= deb;
    end

    // Arbitration and note-length FSM; scaler doubles as the current key
    always_comb begin
        state_n = state;
        cur_n   = scaler;
        hold_n  = (hold_cnt == '0) ? '0 : hold_cnt - 22'd1;
        unique case (state)
            IDLE: begin
                if (|press) begin
                    state_n = PLAY;
                    cur_n   = top_idx(press);
                    hold_n  = HOLD_LOAD;
                end
            end
            PLAY: begin
                if (|press) begin
                    cur_n  = top_idx(press);
                    hold_n = HOLD_LOAD;
                end else if (rel) begin
                    if (|deb) begin
                        cur_n  = top_idx(deb);
                        hold_n = HOLD_LOAD;
                    end else if (hold_cnt == '0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = TAIL;
                    end
                end
            end
            TAIL: begin
                if (|press) begin
                    state_n = PLAY;
                    cur_n   = top_idx(press);
                    hold_n  = HOLD_LOAD;
                end else if (hold_cnt == '0) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        note_on_n = (state_n != IDLE);
        active_n  = note_on_n ? (8'b1 << cur_n) : 8'b0;
    end

    // State, hold timer and registered outputs
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            scaler     <= '0;
            note_on    <= 1'b0;
            active_key <= '0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_n;
            scaler     <= cur_n;
            note_on    <= note_on_n;
            active_key <= active_n;
        end
    end

endmodule
